// File: rtl/serial_frame_tx.sv
// serial_frame_tx: valid/ready word in, start+LSB-first data+[even parity if SERIAL_FRAME_TX_PARITY_EN]+stop out on tx
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par, par_n;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bidx, bidx_n;
  logic [DATA_W-1:0] sr, sr_n;
  logic tx_n, busy_n, rdy_n, done_n, tick;
  assign tick = cnt == CNT_MAX;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bidx     <= '0;
      sr       <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      in_ready <= 1'b1;
      done     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bidx     <= bidx_n;
      sr       <= sr_n;
      tx       <= tx_n;
      busy     <= busy_n;
      in_ready <= rdy_n;
      done     <= done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = tick ? '0 : cnt + CW'(1);
    bidx_n  = bidx;
    sr_n    = sr;
    tx_n    = tx;
    busy_n  = busy;
    rdy_n   = in_ready;
    done_n  = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (in_valid && in_ready) begin
          state_n = START;
          sr_n    = in_data;
          bidx_n  = '0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          rdy_n   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          par_n   = ^in_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          tx_n    = sr[0];
          sr_n    = sr >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bidx == BIT_MAX) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bidx_n = bidx + BW'(1);
            tx_n   = sr[0];
            sr_n   = sr >> 1;
          end
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
          rdy_n   = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        rdy_n   = 1'b1;
      end
    endcase
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: table-driven frame checks at C=4 plus back-to-back at C=1
module tb_serial_frame_tx;
  localparam int C = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int N = 11;
`else
  localparam int N = 10;
`endif
  typedef struct {
    logic [7:0]  d;
    logic [9:0]  enp;
    logic [10:0] ep;
    bit          glitch;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, tx, busy, done;
  logic [7:0] in_data = '0;
  logic b_valid = 1'b0, b_ready, b_tx, b_busy, b_done;
  logic [7:0] b_data = '0;
  int checks = 0, errors = 0;
  vec_t tv[6];
  always #5 clk = ~clk;
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx(tx), .busy(busy), .done(done)
  );
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .tx(b_tx), .busy(b_busy), .done(b_done)
  );
  function automatic logic [10:0] pick(vec_t v);
`ifdef SERIAL_FRAME_TX_PARITY_EN
    return v.ep;
`else
    return {1'b0, v.enp};
`endif
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [10:0] e, input bit glitch);
    int bad_tx = 0, bad_st = 0;
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < N*C; k++) begin
      if (tx !== e[k/C]) bad_tx++;
      if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) bad_st++;
      if (glitch && k == 6) begin
        in_data  = ~d;
        in_valid = 1'b1;
      end
      if (glitch && k == 9) in_valid = 1'b0;
      step();
    end
    chk("frame_bits", bad_tx, 0);
    chk("frame_status", bad_st, 0);
    chk("end_done", done, 1);
    chk("end_ready", in_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_tx", tx, 1);
    step();
    chk("done_once", done, 0);
    chk("no_extra_frame", busy, 0);
  endtask
  initial begin
    int bad, dones;
    logic [10:0] e55, e00, eff;
    logic exp_bit;
    tv[0] = '{8'hA5, 10'b1101001010, 11'b10101001010, 1'b0};
    tv[1] = '{8'h07, 10'b1000001110, 11'b11000001110, 1'b0};
    tv[2] = '{8'h3C, 10'b1001111000, 11'b10001111000, 1'b1};
    tv[3] = '{8'h55, 10'b1010101010, 11'b10010101010, 1'b0};
    tv[4] = '{8'h00, 10'b1000000000, 11'b10000000000, 1'b0};
    tv[5] = '{8'hFF, 10'b1111111110, 11'b10111111110, 1'b0};
    e55 = pick(tv[3]);
    e00 = pick(tv[4]);
    eff = pick(tv[5]);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", tx, 1);
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    bad = 0;
    repeat (5) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    chk("idle_after_rst", bad, 0);
    for (int i = 0; i < 6; i++) send(tv[i].d, pick(tv[i]), tv[i].glitch);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_valid = 1'b0;
    repeat (4*C + 1) step();
    chk("mid_bit3", tx, e55[4]);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    bad = 0;
    repeat (N*C) begin
      step();
      if (done !== 1'b0 || tx !== 1'b1) bad++;
    end
    chk("mid_no_done", bad, 0);
    send(8'h55, e55, 1'b0);
    b_valid = 1'b1;
    b_data  = 8'h00;
    step();
    b_data = 8'hFF;
    bad    = 0;
    dones  = 0;
    for (int k = 0; k <= 2*N + 5; k++) begin
      exp_bit = k < N ? e00[k] : k == N ? 1'b1 : k <= 2*N ? eff[k-N-1] : 1'b1;
      if (b_tx !== exp_bit) bad++;
      if (b_done === 1'b1) dones++;
      if (k == N) chk("b2b_ready", b_ready, 1);
      if (k == N + 1) begin
        chk("b2b_busy2", b_busy, 1);
        b_valid = 1'b0;
      end
      step();
    end
    chk("b2b_bits", bad, 0);
    chk("b2b_dones", dones, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
